// File: rtl/xora_gate.sv
// rtl/xora_gate.sv - combinational XOR with a registered copy, running XOR accumulator
// and a saturating count of enabled cycles where the XOR output was nonzero.
module xora_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_q,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] hi_cnt,
  output logic             hi_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] fq_d, fq_q;
  logic [WIDTH-1:0] acc_d, acc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // The primary output never touches the clocked path.
  assign F = A ^ B;

  always_comb begin
    fq_d  = fq_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (en) begin
      fq_d = F;
    end
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ F;
      if ((|F) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fq_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      fq_q  <= fq_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign F_q    = fq_q;
  assign acc    = acc_q;
  assign hi_cnt = cnt_q;
  assign hi_sat = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_xora_gate.sv
// tb/tb_xora_gate.sv - bench for xora_gate: three instances (1-bit/8-bit count, 1-bit/2-bit count,
// 8-bit/3-bit count) driven from shared inputs and compared against a behavioural model.
module tb_xora_gate;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       en = 1'b0;
  logic       clr = 1'b0;

  logic       u1_f, u1_fq, u1_acc, u1_sat;
  logic [7:0] u1_cnt;
  logic       u2_f, u2_fq, u2_acc, u2_sat;
  logic [1:0] u2_cnt;
  logic [7:0] u4_f, u4_fq, u4_acc;
  logic [2:0] u4_cnt;
  logic       u4_sat;

  xora_gate #(.WIDTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .A(a[0:0]), .B(b[0:0]), .en(en), .clr(clr),
    .F(u1_f), .F_q(u1_fq), .acc(u1_acc), .hi_cnt(u1_cnt), .hi_sat(u1_sat)
  );

  xora_gate #(.WIDTH(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .A(a[0:0]), .B(b[0:0]), .en(en), .clr(clr),
    .F(u2_f), .F_q(u2_fq), .acc(u2_acc), .hi_cnt(u2_cnt), .hi_sat(u2_sat)
  );

  xora_gate #(.WIDTH(8), .CNT_W(3)) u4 (
    .clk(clk), .rst(rst), .A(a), .B(b), .en(en), .clr(clr),
    .F(u4_f), .F_q(u4_fq), .acc(u4_acc), .hi_cnt(u4_cnt), .hi_sat(u4_sat)
  );

  int passed = 0;
  int total  = 0;

  // Reference state: last enabled XOR value, XOR of all enabled values since clear,
  // and uncapped counts of enabled cycles with a nonzero result.
  logic [7:0] m_fq;
  logic [7:0] m_acc;
  int         n_narrow;
  int         n_wide;

  function automatic int capped(input int n, input int max_val);
    return (n > max_val) ? max_val : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_fq = '0; m_acc = '0; n_narrow = 0; n_wide = 0;
  endtask

  task automatic model_edge();
    logic [7:0] f;
    f = a ^ b;
    if (en) m_fq = f;
    if (clr) begin
      m_acc = '0; n_narrow = 0; n_wide = 0;
    end else if (en) begin
      m_acc = m_acc ^ f;
      if (f[0]) n_narrow++;
      if (f != 0) n_wide++;
    end
  endtask

  task automatic tick();
    #5;
    if (!rst) model_edge();
    clk = 1'b1;
    #5;
    clk = 1'b0;
  endtask

  task automatic check_f(input string tag);
    logic [7:0] f;
    f = a ^ b;
    chk({tag, ".u1_f"}, 32'(u1_f), 32'(f[0]));
    chk({tag, ".u2_f"}, 32'(u2_f), 32'(f[0]));
    chk({tag, ".u4_f"}, 32'(u4_f), 32'(f));
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".u1_fq"},  32'(u1_fq),  32'(m_fq[0]));
    chk({tag, ".u1_acc"}, 32'(u1_acc), 32'(m_acc[0]));
    chk({tag, ".u1_cnt"}, 32'(u1_cnt), 32'(capped(n_narrow, 255)));
    chk({tag, ".u1_sat"}, 32'(u1_sat), 32'(n_narrow >= 255));
    chk({tag, ".u2_fq"},  32'(u2_fq),  32'(m_fq[0]));
    chk({tag, ".u2_acc"}, 32'(u2_acc), 32'(m_acc[0]));
    chk({tag, ".u2_cnt"}, 32'(u2_cnt), 32'(capped(n_narrow, 3)));
    chk({tag, ".u2_sat"}, 32'(u2_sat), 32'(n_narrow >= 3));
    chk({tag, ".u4_fq"},  32'(u4_fq),  32'(m_fq));
    chk({tag, ".u4_acc"}, 32'(u4_acc), 32'(m_acc));
    chk({tag, ".u4_cnt"}, 32'(u4_cnt), 32'(capped(n_wide, 7)));
    chk({tag, ".u4_sat"}, 32'(u4_sat), 32'(n_wide >= 7));
  endtask

  initial begin
    logic [1:0] tt_a [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] tt_b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       tt_f [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] seq  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic       exp_fq  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_acc [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] exp_sat_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset state with clk idle.
    #2 rst = 1'b1;
    #1 model_reset();
    check_regs("reset");
    #2 rst = 1'b0;

    // Truth table, clk idle, rst low.
    for (int i = 0; i < 4; i++) begin
      a = 8'(tt_a[i]); b = 8'(tt_b[i]);
      #10;
      chk("tt_rst0.F", 32'(u1_f), 32'(tt_f[i]));
      check_f("tt_rst0");
    end

    // Truth table with rst held high: F still works, registers stay zero.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 8'(tt_a[i]); b = 8'(tt_b[i]);
      #10;
      chk("tt_rst1.F", 32'(u1_f), 32'(tt_f[i]));
      check_regs("tt_rst1");
    end
    en = 1'b1;
    tick();
    check_regs("rst_hold_edge");
    rst = 1'b0;
    en = 1'b0;

    // Registered path with en=1.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 8'(seq[i][1]); b = 8'(seq[i][0]);
      tick();
      chk("seq.F_q", 32'(u1_fq), 32'(exp_fq[i]));
      chk("seq.acc", 32'(u1_acc), 32'(exp_acc[i]));
      check_regs("seq");
    end
    chk("seq.hi_cnt_end", 32'(u1_cnt), 32'd2);

    // Hold with en=0, then clear with en=1.
    en = 1'b0; a = 8'd0; b = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_regs("hold");
    end
    en = 1'b1; clr = 1'b1;
    tick();
    chk("clr.acc", 32'(u1_acc), 32'd0);
    chk("clr.hi_cnt", 32'(u1_cnt), 32'd0);
    chk("clr.F_q", 32'(u1_fq), 32'd1);
    check_regs("clr");
    clr = 1'b0;

    // Saturation on the 2-bit counter.
    a = 8'd1; b = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat.u2_cnt", 32'(u2_cnt), 32'(exp_sat_cnt[i]));
      chk("sat.u2_sat", 32'(u2_sat), 32'(i >= 2));
      check_regs("sat");
    end

    // Async reset between edges while hi_cnt=2.
    clr = 1'b1; tick(); clr = 1'b0;
    tick(); tick();
    chk("async.pre_cnt", 32'(u1_cnt), 32'd2);
    #2 rst = 1'b1;
    #1 model_reset();
    check_regs("async");
    a = 8'h5a; b = 8'h0f;
    #1 check_f("async_f");
    #1 rst = 1'b0;

    // Randomized run against the model, with occasional async reset pulses.
    for (int i = 0; i < 300; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      #1 check_f("rnd_f");
      if ($urandom_range(0, 39) == 0) begin
        #1 rst = 1'b1;
        #1 model_reset();
        check_regs("rnd_rst");
        rst = 1'b0;
      end
      tick();
      check_regs("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
